// File: rtl/uart_periph_if.sv
// CPU-side register bus of the UART peripheral: read/write strobes, byte
// address, write data and combinational read data.
interface uart_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON word registers, a transmit FSM and a
// receive FSM with start-bit glitch rejection, sharing one bit-period setting.
module uart_periph #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic         clk,
  input  logic         reset,
  uart_periph_if.slave bus,
  input  logic         rx,
  output logic         tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [29:0] A_TXD = 30'h1000_0006;  // 0x40000018
  localparam logic [29:0] A_RXD = 30'h1000_0007;  // 0x4000001C
  localparam logic [29:0] A_CON = 30'h1000_0008;  // 0x40000020
  localparam logic [15:0] LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF  = 16'(CLKS_PER_BIT / 2 - 1);

  logic [7:0]  txd, rxd;
  logic        tx_en, rx_en, tx_done, rx_ready, tx_pending;
  state_t      tx_state, rx_state;
  logic [15:0] tx_cnt, rx_cnt;
  logic [7:0]  tx_shift, rx_shift;
  logic [2:0]  tx_bit, rx_bit;
  logic        rx_meta, rx_sync, rx_prev;

  logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con;
  logic tx_load, tx_end, rx_ok;
  logic unused_bits;

  assign sel_txd = (bus.addr[31:2] == A_TXD);
  assign sel_rxd = (bus.addr[31:2] == A_RXD);
  assign sel_con = (bus.addr[31:2] == A_CON);
  assign wr_txd  = bus.wr && sel_txd;
  assign wr_con  = bus.wr && sel_con;

  assign tx_load = (tx_state == S_IDLE) && tx_en && tx_pending;
  assign tx_end  = (tx_state == S_STOP) && (tx_cnt == LAST);
  assign rx_ok   = (rx_state == S_STOP) && (rx_cnt == LAST) && rx_sync && rx_en;

  assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd) begin
      if (sel_txd)      bus.rdata = {24'h0, txd};
      else if (sel_rxd) bus.rdata = {24'h0, rxd};
      else if (sel_con) bus.rdata = {28'h0, rx_ready, tx_done, rx_en, tx_en};
    end
  end

  // Register file. Hardware sets come after the CON write so they win on a shared edge.
  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd        <= 8'h0;
      rxd        <= 8'h0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      tx_done    <= 1'b0;
      rx_ready   <= 1'b0;
      tx_pending <= 1'b0;
    end else begin
      if (wr_txd) begin
        txd        <= bus.wdata[7:0];
        tx_pending <= 1'b1;
      end else if (tx_load) begin
        tx_pending <= 1'b0;
      end
      if (wr_con) begin
        tx_en    <= bus.wdata[0];
        rx_en    <= bus.wdata[1];
        tx_done  <= tx_done & bus.wdata[2];
        rx_ready <= rx_ready & bus.wdata[3];
      end
      if (tx_end) tx_done <= 1'b1;
      if (rx_ok) begin
        rxd      <= rx_shift;
        rx_ready <= 1'b1;
      end
    end
  end

  // Transmit FSM; tx is registered so it never glitches and resets high asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'h0;
      tx_shift <= 8'h0;
      tx_bit   <= 3'd0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_load) begin
            tx_shift <= txd;
            tx_cnt   <= 16'h0;
            tx       <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= 16'h0;
            tx_bit   <= 3'd0;
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= 16'h0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= 16'h0;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM: samples mid-bit; re-arms only on a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= 16'h0;
      rx_shift <= 8'h0;
      rx_bit   <= 3'd0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= 16'h0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt   <= 16'h0;
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= 16'h0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= 16'h0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph at 16 clocks per bit: register-access vector
// table followed by hand-written TX, RX, priority and reset sequences.
module tb_uart_periph;
  localparam int N = 16;
  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic tx;

  uart_periph_if bus_if ();

  uart_periph #(.CLKS_PER_BIT(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if),
    .rx   (rx),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(negedge clk);
    bus_if.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd = 1'b1; bus_if.addr = a;
    #1 d = bus_if.rdata;
    bus_if.rd = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Drives one frame on rx; optionally writes CON=0 on the edge after cycle clr_at.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int clr_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int j = 0; j < 10 * N + 8; j++) begin
      @(negedge clk);
      rx = (j < 10 * N) ? fr[j / N] : 1'b1;
      if (j == clr_at) begin
        bus_if.wr = 1'b1; bus_if.addr = CON; bus_if.wdata = 32'h0;
      end else begin
        bus_if.wr = 1'b0;
      end
    end
  endtask

  // Waits (bounded) for a start bit, then samples all ten bits at mid-bit.
  task automatic tx_capture(input string name, output logic [9:0] fr);
    int n;
    n = 0;
    fr = '1;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start_seen"}, {31'h0, tx}, 32'h0);
    if (tx === 1'b0) begin
      repeat (N / 2) @(negedge clk);
      fr[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (N) @(negedge clk);
        fr[i] = tx;
      end
    end
  endtask

  initial begin
    logic [9:0] exp_fr;
    logic [9:0] f1, f2;
    int lows;

    vecs[0]  = '{1'b0, 1'b1, CON,           32'h0,          32'h0};
    vecs[1]  = '{1'b0, 1'b1, TXD,           32'h0,          32'h0};
    vecs[2]  = '{1'b0, 1'b1, RXD,           32'h0,          32'h0};
    vecs[3]  = '{1'b1, 1'b0, TXD,           32'h1234_56A5,  32'h0};
    vecs[4]  = '{1'b0, 1'b1, TXD,           32'h0,          32'h0000_00A5};
    vecs[5]  = '{1'b0, 1'b1, 32'h4000_001B, 32'h0,          32'h0000_00A5};
    vecs[6]  = '{1'b0, 1'b0, TXD,           32'h0,          32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'hC000_0018, 32'h0,          32'h0};
    vecs[8]  = '{1'b1, 1'b0, RXD,           32'h0000_00FF,  32'h0};
    vecs[9]  = '{1'b0, 1'b1, RXD,           32'h0,          32'h0};
    vecs[10] = '{1'b1, 1'b0, CON,           32'h0000_000E,  32'h0};
    vecs[11] = '{1'b0, 1'b1, CON,           32'h0,          32'h0000_0002};
    vecs[12] = '{1'b1, 1'b0, 32'h5000_0020, 32'h0000_0003,  32'h0};
    vecs[13] = '{1'b0, 1'b1, 32'h4000_0022, 32'h0,          32'h0000_0002};
    vecs[14] = '{1'b1, 1'b0, CON,           32'h0,          32'h0};
    vecs[15] = '{1'b0, 1'b1, CON,           32'h0,          32'h0};

    reset = 1'b1; rx = 1'b1;
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 32'h0; bus_if.wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("tx_in_reset", {31'h0, tx}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    read_check("con_after_reset", CON, 32'h0);
    check("tx_after_reset", {31'h0, tx}, 32'h1);

    // Register access table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_if.wr = vecs[i].wr; bus_if.rd = vecs[i].rd;
      bus_if.addr = vecs[i].addr; bus_if.wdata = vecs[i].wdata;
      #1 check($sformatf("vec%0d", i), bus_if.rdata, vecs[i].exp);
    end
    @(negedge clk);
    bus_if.wr = 1'b0; bus_if.rd = 1'b0;
    check("tx_idle_while_disabled", {31'h0, tx}, 32'h1);

    // Single frame 0x5A: exact bit timing and tx_done after 160 cycles.
    bus_write(TXD, 32'h5A);
    bus_write(CON, 32'h1);
    exp_fr = {1'b1, 8'h5A, 1'b0};
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      if (k >= 9 && (k - 9) % N == 0)
        check($sformatf("tx5a_bit%0d", (k - 9) / N), {31'h0, tx}, {31'h0, exp_fr[(k - 9) / N]});
      if (k == 160) read_check("con_before_done", CON, 32'h1);
      if (k == 161) begin
        read_check("con_tx_done", CON, 32'h5);
        check("tx_idle_after_frame", {31'h0, tx}, 32'h1);
      end
    end
    bus_write(CON, 32'h2);
    read_check("con_tx_done_cleared", CON, 32'h2);

    // Good reception, then clear rx_ready.
    rx_frame(8'hA3, 1'b1, -1);
    read_check("con_rx_ready", CON, 32'hA);
    read_check("rxd_a3", RXD, 32'hA3);
    bus_write(CON, 32'h2);
    read_check("con_rx_cleared", CON, 32'h2);

    // Framing error is discarded.
    rx_frame(8'h3C, 1'b0, -1);
    read_check("con_after_framing_err", CON, 32'h2);
    read_check("rxd_after_framing_err", RXD, 32'hA3);

    // Short low glitch is rejected.
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * N) @(negedge clk);
    read_check("con_after_glitch", CON, 32'h2);
    read_check("rxd_after_glitch", RXD, 32'hA3);

    // CON=0 written on the stop-sample edge: the set wins.
    rx_frame(8'h96, 1'b1, 154);
    read_check("con_set_wins", CON, 32'h8);
    read_check("rxd_96", RXD, 32'h96);

    // rx_en=0 discards the byte.
    rx_frame(8'h77, 1'b1, -1);
    read_check("con_rx_disabled", CON, 32'h8);
    read_check("rxd_rx_disabled", RXD, 32'h96);

    // New byte while rx_ready=1 overwrites RXD.
    bus_write(CON, 32'hA);
    read_check("con_keep_ready", CON, 32'hA);
    rx_frame(8'hC5, 1'b1, -1);
    read_check("rxd_overwrite", RXD, 32'hC5);
    read_check("con_overwrite", CON, 32'hA);

    // Back-to-back frames; TXD rewritten mid-frame.
    bus_write(CON, 32'h1);
    bus_write(TXD, 32'h11);
    fork
      tx_capture("b2b_first", f1);
      begin
        repeat (40) @(negedge clk);
        bus_write(TXD, 32'h22);
      end
    join
    tx_capture("b2b_second", f2);
    check("b2b_frame1", {22'h0, f1}, {22'h0, 1'b1, 8'h11, 1'b0});
    check("b2b_frame2", {22'h0, f2}, {22'h0, 1'b1, 8'h22, 1'b0});
    repeat (2 * N) @(negedge clk);
    read_check("con_after_b2b", CON, 32'h5);

    // Reset in the middle of a frame.
    bus_write(TXD, 32'h00);
    repeat (40) @(negedge clk);
    check("tx_low_before_reset", {31'h0, tx}, 32'h0);
    #2 reset = 1'b1;
    #1 check("tx_async_reset", {31'h0, tx}, 32'h1);
    read_check("con_in_reset", CON, 32'h0);
    read_check("txd_in_reset", TXD, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 12 * N; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_tx_after_reset", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
